// File: rtl/mem_stage.sv
// Pipeline MEM stage: services LDW/STW against a word-addressed data memory and LED/HEX/switch MMIO
// registers, stalls upstream while a multi-cycle load is in flight, and passes all other results to WB.
module mem_stage #(
    parameter int          DMEM_AW     = 10,
    parameter int          MEM_LATENCY = 2,
    parameter logic [15:0] LED_ADDR    = 16'hFFF0,
    parameter logic [15:0] HEX_ADDR    = 16'hFFF2,
    parameter logic [15:0] SW_ADDR     = 16'hFFF4,
    parameter logic [7:0]  OP_LDW      = 8'h06,
    parameter logic [7:0]  OP_STW      = 8'h07
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic        I_LOCK,
    input  logic [15:0] I_PC,
    input  logic [31:0] I_IR,
    input  logic [7:0]  I_Opcode,
    input  logic        I_EX_Valid,
    input  logic [3:0]  I_DestRegIdx,
    input  logic [15:0] I_DestValue,
    input  logic [2:0]  I_CCValue,
    input  logic        I_RegWEn,
    input  logic        I_CCWEn,
    input  logic [15:0] I_MARValue,
    input  logic [15:0] I_MDRValue,
    input  logic [9:0]  I_SW,
    output logic        O_LOCK,
    output logic [15:0] O_PC,
    output logic [31:0] O_IR,
    output logic [7:0]  O_Opcode,
    output logic        O_MEM_Valid,
    output logic [3:0]  O_DestRegIdx,
    output logic [15:0] O_DestValue,
    output logic [2:0]  O_CCValue,
    output logic        O_RegWEn,
    output logic        O_CCWEn,
    output logic [9:0]  O_LEDR,
    output logic [15:0] O_HEX,
    output logic        O_MEMStallSignal
);

    typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_t;

    logic [15:0]        dmem_r [0:(2**DMEM_AW)-1];
    state_t             state_r, state_nxt_s;
    logic [1:0]         cnt_r, cnt_nxt_s;
    logic [15:0]        ld_addr_r;
    logic [3:0]         ld_dest_r;
    logic [2:0]         ld_cc_r;
    logic               stall_s;
    logic               accept_s, is_ld_s, is_st_s;
    logic [15:0]        rd_addr_s, rd_data_s;

    function automatic logic [DMEM_AW-1:0] word_idx(input logic [15:0] addr);
        return addr[DMEM_AW:1];
    endfunction

    function automatic logic is_mmio(input logic [15:0] addr);
        return (addr == LED_ADDR) || (addr == HEX_ADDR) || (addr == SW_ADDR);
    endfunction

    assign accept_s         = I_LOCK & I_EX_Valid & (state_r == IDLE);
    assign is_ld_s          = (I_Opcode == OP_LDW);
    assign is_st_s          = (I_Opcode == OP_STW);
    assign O_MEMStallSignal = stall_s & ~I_RESET;

    // During a pending load the latched address is read, so upstream changes cannot disturb it
    assign rd_addr_s = (state_r == LD_WAIT) ? ld_addr_r : I_MARValue;

    // Read mux: MMIO registers take priority over DMEM
    always_comb begin
        rd_data_s = 16'h0000;
        if (rd_addr_s == LED_ADDR) begin
            rd_data_s = {6'b000000, O_LEDR};
        end else if (rd_addr_s == HEX_ADDR) begin
            rd_data_s = O_HEX;
        end else if (rd_addr_s == SW_ADDR) begin
            rd_data_s = {6'b000000, I_SW};
        end else begin
            rd_data_s = dmem_r[word_idx(rd_addr_s)];
        end
    end

    // Load FSM next-state, wait counter and stall request
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        if (!I_LOCK) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && is_ld_s && (MEM_LATENCY > 1)) begin
                        state_nxt_s = LD_WAIT;
                        cnt_nxt_s   = 2'(MEM_LATENCY - 2);
                        stall_s     = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LD_WAIT: begin
                    if (cnt_r != 2'd0) begin
                        cnt_nxt_s = cnt_r - 2'd1;
                        stall_s   = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 2'd0;
                end
            endcase
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET && accept_s && is_st_s && !is_mmio(I_MARValue)) begin
            dmem_r[word_idx(I_MARValue)] <= I_MDRValue;
        end
    end

    // Stage registers, FSM state and MMIO registers
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            ld_addr_r    <= 16'h0000;
            ld_dest_r    <= 4'h0;
            ld_cc_r      <= 3'b000;
            O_LOCK       <= 1'b0;
            O_PC         <= 16'h0000;
            O_IR         <= 32'h0000_0000;
            O_Opcode     <= 8'h00;
            O_MEM_Valid  <= 1'b0;
            O_DestRegIdx <= 4'h0;
            O_DestValue  <= 16'h0000;
            O_CCValue    <= 3'b000;
            O_RegWEn     <= 1'b0;
            O_CCWEn      <= 1'b0;
            O_LEDR       <= 10'h000;
            O_HEX        <= 16'h0000;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            O_LOCK   <= I_LOCK;
            O_PC     <= I_PC;
            O_IR     <= I_IR;
            O_Opcode <= I_Opcode;
            if (!I_LOCK) begin
                O_MEM_Valid <= 1'b0;
                O_RegWEn    <= 1'b0;
                O_CCWEn     <= 1'b0;
            end else if (state_r == LD_WAIT) begin
                O_MEM_Valid <= (cnt_r == 2'd0);
                O_RegWEn    <= (cnt_r == 2'd0);
                O_CCWEn     <= 1'b0;
                if (cnt_r == 2'd0) begin
                    O_DestValue  <= rd_data_s;
                    O_DestRegIdx <= ld_dest_r;
                    O_CCValue    <= ld_cc_r;
                end
            end else if (accept_s) begin
                O_DestRegIdx <= I_DestRegIdx;
                O_CCValue    <= I_CCValue;
                O_CCWEn      <= 1'b0;
                if (is_ld_s && (MEM_LATENCY > 1)) begin
                    O_MEM_Valid <= 1'b0;
                    O_RegWEn    <= 1'b0;
                    ld_addr_r   <= I_MARValue;
                    ld_dest_r   <= I_DestRegIdx;
                    ld_cc_r     <= I_CCValue;
                end else if (is_ld_s) begin
                    O_MEM_Valid <= 1'b1;
                    O_RegWEn    <= 1'b1;
                    O_DestValue <= rd_data_s;
                end else if (is_st_s) begin
                    O_MEM_Valid <= 1'b1;
                    O_RegWEn    <= 1'b0;
                    O_DestValue <= I_DestValue;
                    if (I_MARValue == LED_ADDR) begin
                        O_LEDR <= I_MDRValue[9:0];
                    end else if (I_MARValue == HEX_ADDR) begin
                        O_HEX <= I_MDRValue;
                    end
                end else begin
                    O_MEM_Valid <= 1'b1;
                    O_RegWEn    <= I_RegWEn;
                    O_CCWEn     <= I_CCWEn;
                    O_DestValue <= I_DestValue;
                end
            end else begin
                O_MEM_Valid <= 1'b0;
                O_RegWEn    <= 1'b0;
                O_CCWEn     <= 1'b0;
            end
        end
    end

endmodule
